// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 receiver.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ps2_pkg;

    // Frame deframer states; one transition per filtered ps2_clk fall
    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } state_t;

    localparam logic [7:0] BREAK_PREFIX = 8'hF0;
    localparam logic [7:0] EXT_PREFIX   = 8'hE0;
    localparam int         DATA_BITS    = 8;

    // PS/2 uses odd parity: data bits plus parity bit hold an odd number of ones
    function automatic logic odd_parity_ok(input logic [7:0] data_byte, input logic parity_bit);
        return ^{data_byte, parity_bit};
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Synchronise an async pin, then only accept a level that holds for FILT_LEN samples.
// Latency: SYNC_STAGES + FILT_LEN clk cycles from pin change to filt/fall.
// Backpressure: none; free-running, fall is a one-cycle event.
module ps2_line_filter #(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic pin,
    output logic filt,
    output logic fall
);

    // Counter only needs to reach FILT_LEN-1; the sample that would push it
    // past that value is the one that commits the new level.
    localparam int              CW       = (FILT_LEN < 2) ? 1 : $clog2(FILT_LEN);
    localparam logic [CW-1:0]   CNT_LAST = CW'(FILT_LEN - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   synced;
    logic [CW-1:0]          agree_cnt;

    // Metastability chain, preset high so an idle bus looks idle out of reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pin};
        end
    end

    assign synced = sync_q[SYNC_STAGES-1];

    // Count consecutive samples that disagree with the filtered level; any
    // agreeing sample restarts the count, so short glitches never commit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            filt      <= 1'b1;
            fall      <= 1'b0;
            agree_cnt <= '0;
        end else begin
            fall <= 1'b0;
            if (synced == filt) begin
                agree_cnt <= '0;
            end else if (agree_cnt == CNT_LAST) begin
                filt      <= synced;
                fall      <= ~synced;
                agree_cnt <= '0;
            end else begin
                agree_cnt <= agree_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ps2_rx.sv
// PS/2 keyboard receiver: deframes 11-bit frames, folds F0/E0 prefixes into flags.
// Latency: scancode_valid one clk after the filtered fall that samples the stop bit.
// Backpressure: none; scancode is held until the next good byte, valid is a strobe.
module ps2_rx
    import ps2_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int FILT_LEN       = 4,
    parameter int TIMEOUT_CYCLES = 200000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] scancode,
    output logic       scancode_valid,
    output logic       is_break,
    output logic       is_extended,
    output logic       parity_err,
    output logic       frame_err
);

    localparam int            TW       = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [2:0]    BIT_LAST = 3'(DATA_BITS - 1);

    logic                   clk_filt;
    logic                   clk_fall;
    logic                   clk_filt_q;
    logic                   clk_edge;
    logic [SYNC_STAGES-1:0] data_sync_q;
    logic                   data_s;

    state_t                 state;
    logic [2:0]             bit_cnt;
    logic [7:0]             shreg;
    logic                   par_bit;
    logic                   break_pend;
    logic                   ext_pend;
    logic [TW-1:0]          to_cnt;
    logic                   timeout_hit;

    // ps2_clk needs deglitching because every edge advances the deframer
    ps2_line_filter #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILT_LEN    (FILT_LEN)
    ) u_clk_filter (
        .clk     (clk),
        .reset_n (reset_n),
        .pin     (ps2_clk),
        .filt    (clk_filt),
        .fall    (clk_fall)
    );

    // ps2_data is stable around the clock fall, so synchronising is enough
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_sync_q <= '1;
        end else begin
            data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], ps2_data};
        end
    end

    assign data_s = data_sync_q[SYNC_STAGES-1];

    // Delayed copy of the filtered clock to spot both rise and fall edges
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            clk_filt_q <= 1'b1;
        end else begin
            clk_filt_q <= clk_filt;
        end
    end

    assign clk_edge = clk_filt ^ clk_filt_q;

    // Idle-time counter: restarts on any clock activity, held clear in IDLE, saturates
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            to_cnt <= '0;
        end else if (state == IDLE || clk_edge) begin
            to_cnt <= '0;
        end else if (to_cnt != TO_LAST) begin
            to_cnt <= to_cnt + 1'b1;
        end
    end

    // A real fall on the expiry cycle wins; the frame is still alive
    assign timeout_hit = (state != IDLE) && (to_cnt == TO_LAST) && !clk_fall;

    // Deframer FSM with registered outputs; all strobes default low each cycle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            bit_cnt        <= '0;
            shreg          <= '0;
            par_bit        <= 1'b0;
            break_pend     <= 1'b0;
            ext_pend       <= 1'b0;
            scancode       <= '0;
            scancode_valid <= 1'b0;
            is_break       <= 1'b0;
            is_extended    <= 1'b0;
            parity_err     <= 1'b0;
            frame_err      <= 1'b0;
        end else begin
            scancode_valid <= 1'b0;
            parity_err     <= 1'b0;
            frame_err      <= 1'b0;
            if (clk_fall) begin
                case (state)
                    IDLE: begin
                        // A high data line on a fall is not a start bit; ignore quietly
                        if (!data_s) begin
                            state   <= DATA;
                            bit_cnt <= '0;
                        end
                    end
                    DATA: begin
                        // LSB arrives first, so shift right and insert at the top
                        shreg <= {data_s, shreg[7:1]};
                        if (bit_cnt == BIT_LAST) begin
                            state <= PARITY;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                    PARITY: begin
                        par_bit <= data_s;
                        state   <= STOP;
                    end
                    STOP: begin
                        state <= IDLE;
                        if (!data_s) begin
                            // Framing error dominates a simultaneous parity error
                            frame_err  <= 1'b1;
                            break_pend <= 1'b0;
                            ext_pend   <= 1'b0;
                        end else if (!odd_parity_ok(shreg, par_bit)) begin
                            parity_err <= 1'b1;
                            break_pend <= 1'b0;
                            ext_pend   <= 1'b0;
                        end else if (shreg == BREAK_PREFIX) begin
                            break_pend <= 1'b1;
                        end else if (shreg == EXT_PREFIX) begin
                            ext_pend <= 1'b1;
                        end else begin
                            scancode       <= shreg;
                            is_break       <= break_pend;
                            is_extended    <= ext_pend;
                            scancode_valid <= 1'b1;
                            break_pend     <= 1'b0;
                            ext_pend       <= 1'b0;
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end else if (timeout_hit) begin
                // Device went quiet mid-frame: drop the partial byte and any prefixes
                frame_err  <= 1'b1;
                break_pend <= 1'b0;
                ext_pend   <= 1'b0;
                state      <= IDLE;
            end
        end
    end

endmodule

// File: tb/tb_ps2_rx.sv
// Directed bench for ps2_rx: table of whole frames plus timeout, glitch and reset sequences.
module tb_ps2_rx;

    localparam int HALF = 40;     // ps2_clk half period in clk cycles
    localparam int TO   = 1000;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [7:0] scancode;
    logic       scancode_valid;
    logic       is_break;
    logic       is_extended;
    logic       parity_err;
    logic       frame_err;

    always #5 clk = ~clk;

    ps2_rx #(
        .SYNC_STAGES    (2),
        .FILT_LEN       (4),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .ps2_clk        (ps2_clk),
        .ps2_data       (ps2_data),
        .scancode       (scancode),
        .scancode_valid (scancode_valid),
        .is_break       (is_break),
        .is_extended    (is_extended),
        .parity_err     (parity_err),
        .frame_err      (frame_err)
    );

    int total = 0;
    int bad   = 0;
    int n_valid = 0;
    int n_perr  = 0;
    int n_ferr  = 0;
    int run      = 0;
    int last_run = 0;

    // Pulse counters and strobe-width tracker, sampled away from the active edge
    always @(negedge clk) begin
        if (scancode_valid) begin
            n_valid++;
            run++;
        end else begin
            if (run > 0) last_run = run;
            run = 0;
        end
        if (parity_err) n_perr++;
        if (frame_err)  n_ferr++;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [10:0] mk(input logic [7:0] b, input bit badp, input bit stop);
        logic p;
        p = (~^b) ^ badp;
        return {stop, p, b, 1'b0};
    endfunction

    // Drive nb bits LSB first; data set while clock is high, sampled on the fall.
    // glitch_bit selects a bit whose high phase gets a 3-cycle low pulse.
    task automatic send_bits(input logic [10:0] f, input int nb, input int glitch_bit);
        for (int i = 0; i < nb; i++) begin
            ps2_data = f[i];
            if (i == glitch_bit) begin
                wait_cyc(HALF / 2);
                ps2_clk = 1'b0;
                wait_cyc(3);
                ps2_clk = 1'b1;
                wait_cyc(HALF - HALF / 2 - 3);
            end else begin
                wait_cyc(HALF);
            end
            ps2_clk = 1'b0;
            wait_cyc(HALF);
            ps2_clk = 1'b1;
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input bit badp, input bit stop, input int glitch_bit);
        send_bits(mk(b, badp, stop), 11, glitch_bit);
        ps2_data = 1'b1;
        wait_cyc(HALF);
        wait_cyc(20);
    endtask

    typedef struct {
        logic [7:0] b;
        bit         badp;
        bit         stop;
        int         exp_v;
        logic [7:0] exp_sc;
        bit         exp_brk;
        bit         exp_ext;
        int         exp_pe;
        int         exp_fe;
    } vec_t;

    vec_t tbl [13];

    initial begin
        int sv, sp, sf, k;
        bit seen;

        tbl[0]  = '{8'h1C, 1'b0, 1'b1, 1, 8'h1C, 1'b0, 1'b0, 0, 0};
        tbl[1]  = '{8'hF0, 1'b0, 1'b1, 0, 8'h1C, 1'b0, 1'b0, 0, 0};
        tbl[2]  = '{8'h1C, 1'b0, 1'b1, 1, 8'h1C, 1'b1, 1'b0, 0, 0};
        tbl[3]  = '{8'hE0, 1'b0, 1'b1, 0, 8'h1C, 1'b1, 1'b0, 0, 0};
        tbl[4]  = '{8'hF0, 1'b0, 1'b1, 0, 8'h1C, 1'b1, 1'b0, 0, 0};
        tbl[5]  = '{8'h75, 1'b0, 1'b1, 1, 8'h75, 1'b1, 1'b1, 0, 0};
        tbl[6]  = '{8'h29, 1'b0, 1'b1, 1, 8'h29, 1'b0, 1'b0, 0, 0};
        tbl[7]  = '{8'h1C, 1'b1, 1'b1, 0, 8'h29, 1'b0, 1'b0, 1, 0};
        tbl[8]  = '{8'h1C, 1'b0, 1'b0, 0, 8'h29, 1'b0, 1'b0, 0, 1};
        tbl[9]  = '{8'hE0, 1'b0, 1'b1, 0, 8'h29, 1'b0, 1'b0, 0, 0};
        tbl[10] = '{8'h1C, 1'b1, 1'b1, 0, 8'h29, 1'b0, 1'b0, 1, 0};
        tbl[11] = '{8'h5A, 1'b0, 1'b1, 1, 8'h5A, 1'b0, 1'b0, 0, 0};
        tbl[12] = '{8'h1C, 1'b1, 1'b0, 0, 8'h5A, 1'b0, 1'b0, 0, 1};

        // Reset state
        wait_cyc(5);
        chk("rst_scancode", 32'(scancode), 32'h00);
        chk("rst_valid", 32'(scancode_valid), 32'h0);
        chk("rst_break", 32'(is_break), 32'h0);
        chk("rst_ext", 32'(is_extended), 32'h0);
        chk("rst_perr", 32'(parity_err), 32'h0);
        chk("rst_ferr", 32'(frame_err), 32'h0);
        reset_n = 1'b1;
        wait_cyc(20);

        // Frame table
        for (int i = 0; i < 13; i++) begin
            sv = n_valid; sp = n_perr; sf = n_ferr; last_run = 0;
            send_frame(tbl[i].b, tbl[i].badp, tbl[i].stop, -1);
            chk($sformatf("v%0d_strobes", i), 32'(n_valid - sv), 32'(tbl[i].exp_v));
            chk($sformatf("v%0d_strobe_width", i), 32'(last_run), 32'(tbl[i].exp_v));
            chk($sformatf("v%0d_scancode", i), 32'(scancode), 32'(tbl[i].exp_sc));
            chk($sformatf("v%0d_break", i), 32'(is_break), 32'(tbl[i].exp_brk));
            chk($sformatf("v%0d_ext", i), 32'(is_extended), 32'(tbl[i].exp_ext));
            chk($sformatf("v%0d_perr", i), 32'(n_perr - sp), 32'(tbl[i].exp_pe));
            chk($sformatf("v%0d_ferr", i), 32'(n_ferr - sf), 32'(tbl[i].exp_fe));
        end

        // Timeout: start + 5 data bits then the clock stays high
        sv = n_valid; sp = n_perr; sf = n_ferr;
        send_bits(mk(8'h1C, 1'b0, 1'b1), 6, -1);
        ps2_data = 1'b1;
        k = 0;
        seen = 1'b0;
        while (!seen && k < 3000) begin
            wait_cyc(1);
            k++;
            if (frame_err) seen = 1'b1;
        end
        chk("to_seen", 32'(seen), 32'h1);
        chk("to_in_window", 32'((k >= TO) && (k <= TO + 20)), 32'h1);
        wait_cyc(5);
        chk("to_ferr_count", 32'(n_ferr - sf), 32'h1);
        chk("to_no_strobe", 32'(n_valid - sv), 32'h0);
        chk("to_no_perr", 32'(n_perr - sp), 32'h0);
        wait_cyc(20);
        sv = n_valid;
        send_frame(8'h29, 1'b0, 1'b1, -1);
        chk("after_to_scancode", 32'(scancode), 32'h29);
        chk("after_to_strobes", 32'(n_valid - sv), 32'h1);

        // Glitch shorter than the filter during a data bit
        sv = n_valid; sp = n_perr; sf = n_ferr;
        send_frame(8'h34, 1'b0, 1'b1, 3);
        chk("glitch_scancode", 32'(scancode), 32'h34);
        chk("glitch_strobes", 32'(n_valid - sv), 32'h1);
        chk("glitch_errs", 32'((n_perr - sp) + (n_ferr - sf)), 32'h0);

        // Reset mid-frame, with a break prefix pending
        send_frame(8'hF0, 1'b0, 1'b1, -1);
        send_bits(mk(8'h5A, 1'b0, 1'b1), 4, -1);
        ps2_data = 1'b1;
        wait_cyc(3);
        reset_n = 1'b0;
        wait_cyc(3);
        chk("mrst_scancode", 32'(scancode), 32'h00);
        chk("mrst_break", 32'(is_break), 32'h0);
        chk("mrst_ext", 32'(is_extended), 32'h0);
        chk("mrst_valid", 32'(scancode_valid), 32'h0);
        reset_n = 1'b1;
        sv = n_valid; sf = n_ferr;
        wait_cyc(40);
        chk("mrst_no_delivery", 32'(n_valid - sv), 32'h0);
        chk("mrst_scancode_held", 32'(scancode), 32'h00);
        send_frame(8'h1C, 1'b0, 1'b1, -1);
        chk("mrst_next_scancode", 32'(scancode), 32'h1C);
        chk("mrst_next_strobes", 32'(n_valid - sv), 32'h1);
        chk("mrst_next_break", 32'(is_break), 32'h0);
        chk("mrst_next_ferr", 32'(n_ferr - sf), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ps2_rx.md
Name: ps2_rx

Overview:
- PS/2 keyboard receiver; the stage directly upstream of the scancode change-detect filter.
- Synchronises and deglitches the raw ps2_clk/ps2_data pins, deframes 11-bit frames (start, 8 data LSB-first, odd parity, stop) and checks them.
- Folds the 0xF0 (break) and 0xE0 (extended) prefixes into flags.
- Presents a held, stable 8-bit scancode plus a one-cycle valid strobe.

Parameters:
- SYNC_STAGES, 2: flip-flop stages on each PS/2 pin; minimum 2.
- FILT_LEN, 4: consecutive equal synced samples required before the filtered ps2_clk changes.
- TIMEOUT_CYCLES, 200000: clk cycles without a filtered ps2_clk edge before a partial frame is abandoned (2 ms at 100 MHz).

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- ps2_clk  in  1  raw PS/2 clock pin, asynchronous
- ps2_data  in  1  raw PS/2 data pin, asynchronous
- scancode  out  8  last good non-prefix byte; held between frames
- scancode_valid  out  1  one-cycle pulse when scancode/is_break/is_extended update
- is_break  out  1  current scancode was preceded by 0xF0
- is_extended  out  1  current scancode was preceded by 0xE0
- parity_err  out  1  one-cycle pulse: frame discarded, bad parity
- frame_err  out  1  one-cycle pulse: frame discarded, bad stop bit or timeout

Behaviour:
- Reset (async assert, sync release):
  - All outputs 0; FSM in IDLE; bit counter, shift register, timeout counter and prefix flags cleared.
  - Sync flops and filtered clock preset to 1 (idle bus high).
- Filter: filtered clock takes the synced ps2_clk value once FILT_LEN consecutive samples agree. A fall event is a registered 1->0 transition of the filtered clock.
  - Pin-to-event latency: SYNC_STAGES+FILT_LEN cycles.
  - Pulses shorter than FILT_LEN cycles are ignored.
- ps2_data is synchronised only and sampled on the fall event.
- FSM, advancing only on fall events:
  - IDLE: data=0 -> DATA with bit_cnt=0; data=1 -> stay in IDLE (spurious edge ignored, no error).
  - DATA: shift right, new bit into bit[7]; after 8th bit (bit_cnt=7) -> PARITY.
  - PARITY: store bit -> STOP.
  - STOP: evaluate and always return to IDLE, as follows:
    - stop=0 -> frame_err.
    - stop=1 and XOR(byte, parity) = 0 -> parity_err.
    - Otherwise the frame is good.
    - If stop=0 and parity is also bad, only frame_err is raised.
- Good frame:
  - byte=0xF0: set break_pend; no strobe.
  - byte=0xE0: set ext_pend; no strobe.
  - Any other byte: on the next clk edge, scancode<=byte, is_break<=break_pend, is_extended<=ext_pend, scancode_valid=1 for exactly one cycle; pends cleared.
- Errors: byte discarded; break_pend and ext_pend cleared; scancode, is_break and is_extended retain old values.
- Timeout:
  - Counter clears on every filtered edge (rise or fall) and while in IDLE.
  - In any non-IDLE state, reaching TIMEOUT_CYCLES-1 pulses frame_err, clears pends and returns to IDLE.
  - Counter saturates; width is clog2(TIMEOUT_CYCLES).
- Simultaneous events: a fall event on the timeout-expiry cycle is processed as a fall event, and the timeout does not fire.
- Mid-frame reset: immediate abort, nothing delivered.
- Receive-only: ps2_clk/ps2_data are never driven.
- Back-to-back frames need no dead time beyond one clk cycle between the STOP fall and the next start fall.

Decomposition:
- Package ps2_pkg holds:
  - state enum {IDLE, DATA, PARITY, STOP};
  - constants BREAK_PREFIX=8'hF0, EXT_PREFIX=8'hE0, DATA_BITS=8.
- Sub-module ps2_line_filter(clk, reset_n, pin, filt, fall), carrying SYNC_STAGES and FILT_LEN:
  - instantiated once for ps2_clk;
  - ps2_data uses a plain synchroniser.

Test Plan:
- Frame 0x1C, parity 0, stop 1, 60 us bit period -> scancode=0x1C, scancode_valid high exactly 1 cycle, is_break=0, is_extended=0, no error pulses.
- Frames F0, 1C -> no strobe after F0; after 1C: scancode=0x1C, is_break=1, is_extended=0.
- Frames E0, F0, 75 -> single strobe with scancode=0x75, is_extended=1, is_break=1. A following 0x29 frame -> is_break=0, is_extended=0.
- Frame 0x1C with parity 1 -> parity_err 1-cycle pulse, no strobe, scancode keeps its previous value.
- Frame 0x1C with stop 0 -> frame_err pulse, no strobe.
- 5 bits then clock stops (TIMEOUT_CYCLES=1000 in test) -> frame_err pulse 1000 cycles after the last edge. Next clean 0x29 frame is received correctly.
- Glitch on ps2_clk low for FILT_LEN-1 cycles during DATA -> no bit consumed, frame decodes correctly.
- reset_n pulsed low mid-frame -> all outputs 0, FSM back to IDLE. Next 0x1C frame decodes correctly.
